multi_channel_capture: RTL and testbench

Parametrised successor to the single-channel digitizer datapath. It captures NCH already-deserialised ADC channels into per-channel circular buffers that share one write address. Capture supports a programmable pre-trigger window and external, self-threshold or combined triggering. After capture it streams the record out channel-major over a valid/ready port. It sits between the LVDS receiver/deframer bank and the readout/SPI controller, in a single clock domain.

---
 rtl/multi_channel_capture.sv | 244 ++++++++++++++++++++++++
 tb/tb_multi_channel_capture.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_capture.sv
// rtl/multi_channel_capture.sv - multi-channel ADC capture with pre-trigger ring buffer and streamed readout
module multi_channel_capture #(
  parameter int NCH   = 4,
  parameter int WIDTH = 12,
  parameter int SIZE  = 10
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 arm,
  input  logic                 sample_valid,
  input  logic [NCH*WIDTH-1:0] sample_data,
  input  logic                 ext_trigger,
  input  logic [1:0]           trig_mode,
  input  logic [NCH-1:0]       trig_chan_mask,
  input  logic [WIDTH-1:0]     threshold,
  input  logic [SIZE-1:0]      pre_samples,
  input  logic [SIZE-1:0]      post_samples,
  input  logic                 data_ready,
  output logic [WIDTH-1:0]     data_out,
  output logic                 data_valid,
  output logic                 data_last,
  output logic                 busy,
  output logic                 triggered,
  output logic                 ro_done_n,
  output logic [2:0]           state
);

  localparam int DEPTH = 1 << SIZE;
  localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [SIZE:0] MAX_LEN = (SIZE+1)'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FILL    = 3'd1,
    S_WAIT    = 3'd2,
    S_POST    = 3'd3,
    S_READOUT = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t cur_st, nxt_st;

  // Configuration captured at arm so the host may change inputs mid-record
  logic [1:0]       cfg_mode;
  logic [NCH-1:0]   cfg_mask;
  logic [WIDTH-1:0] cfg_thr;
  logic [SIZE-1:0]  cfg_pre;
  logic [SIZE:0]    post_eff;
  logic [SIZE:0]    rec_len;

  // Capture-side state
  logic [SIZE-1:0]      wr_ptr;
  logic [SIZE:0]        cnt;
  logic [SIZE:0]        cnt_inc;
  logic                 ext_pend;
  logic                 have_prev;
  logic [NCH*WIDTH-1:0] prev_data;
  logic [SIZE-1:0]      trig_addr;

  // Readout pipeline: issue counters, RAM output stage (s1), output register
  logic                 rd_more;
  logic [CHW-1:0]       rd_ch;
  logic [SIZE:0]        rd_idx;
  logic [SIZE-1:0]      rd_addr;
  logic                 rd_is_last;
  logic                 rd_issue;
  logic [NCH*WIDTH-1:0] rd_row;
  logic                 s1_v;
  logic [CHW-1:0]       s1_ch;
  logic                 s1_last;
  logic [WIDTH-1:0]     s1_word;
  logic                 out_free;

  logic                 wr_en, arm_go, ext_en, self_en, self_hit, trig_fire;
  logic                 last_acc, enter_ro;
  logic [SIZE:0]        sum_pp, post_clamp, post_new;

  logic [NCH*WIDTH-1:0] mem [DEPTH];

  // Trigger qualification, clamp arithmetic and readout addressing
  always_comb begin
    wr_en    = sample_valid && (cur_st == S_FILL || cur_st == S_WAIT || cur_st == S_POST);
    arm_go   = arm && (cur_st == S_IDLE || cur_st == S_DONE);
    ext_en   = (cfg_mode == 2'b00) || (cfg_mode == 2'b10);
    self_en  = (cfg_mode == 2'b01) || (cfg_mode == 2'b10);
    cnt_inc  = cnt + 1'b1;
    self_hit = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      if (cfg_mask[c] && have_prev &&
          prev_data[c*WIDTH +: WIDTH] < cfg_thr &&
          sample_data[c*WIDTH +: WIDTH] >= cfg_thr)
        self_hit = 1'b1;
    end
    trig_fire = (cur_st == S_WAIT) && sample_valid &&
                ((ext_en && (ext_trigger || ext_pend)) || (self_en && self_hit));
    sum_pp = {1'b0, pre_samples} + {1'b0, post_samples};
    if (sum_pp > MAX_LEN) post_clamp = MAX_LEN - {1'b0, pre_samples};
    else                  post_clamp = {1'b0, post_samples};
    post_new   = (post_clamp == '0) ? (SIZE+1)'(1) : post_clamp;
    rd_addr    = trig_addr - cfg_pre + rd_idx[SIZE-1:0];
    rd_is_last = (rd_ch == CHW'(NCH - 1)) && (rd_idx == rec_len - 1'b1);
    out_free   = !data_valid || data_ready;
    rd_issue   = (cur_st == S_READOUT) && rd_more && (!s1_v || out_free);
    last_acc   = data_valid && data_ready && data_last;
    s1_word    = '0;
    for (int c = 0; c < NCH; c++) begin
      if (s1_ch == CHW'(c)) s1_word = rd_row[c*WIDTH +: WIDTH];
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset_n) cur_st <= S_IDLE;
    else          cur_st <= nxt_st;
  end

  // FSM next-state logic
  always_comb begin
    nxt_st = cur_st;
    case (cur_st)
      S_IDLE, S_DONE: if (arm) nxt_st = S_FILL;
      S_FILL: begin
        if (cfg_pre == '0) nxt_st = S_WAIT;
        else if (sample_valid && cnt_inc == {1'b0, cfg_pre}) nxt_st = S_WAIT;
      end
      S_WAIT:    if (trig_fire) nxt_st = (post_eff == (SIZE+1)'(1)) ? S_READOUT : S_POST;
      S_POST:    if (sample_valid && cnt_inc == post_eff) nxt_st = S_READOUT;
      S_READOUT: if (last_acc) nxt_st = S_DONE;
      default:   nxt_st = S_IDLE;
    endcase
    enter_ro = (cur_st != S_READOUT) && (nxt_st == S_READOUT);
  end

  // FSM outputs
  always_comb begin
    state     = cur_st;
    busy      = (cur_st == S_FILL) || (cur_st == S_WAIT) || (cur_st == S_POST) || (cur_st == S_READOUT);
    ro_done_n = (cur_st != S_DONE);
  end

  // Capture control: config latch, write pointer, fill/post counting, trigger bookkeeping
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cfg_mode  <= '0;
      cfg_mask  <= '0;
      cfg_thr   <= '0;
      cfg_pre   <= '0;
      post_eff  <= '0;
      rec_len   <= '0;
      wr_ptr    <= '0;
      cnt       <= '0;
      ext_pend  <= 1'b0;
      have_prev <= 1'b0;
      prev_data <= '0;
      trig_addr <= '0;
      triggered <= 1'b0;
    end else begin
      if (arm_go) begin
        cfg_mode  <= trig_mode;
        cfg_mask  <= trig_chan_mask;
        cfg_thr   <= threshold;
        cfg_pre   <= pre_samples;
        post_eff  <= post_new;
        rec_len   <= {1'b0, pre_samples} + post_new;
        cnt       <= '0;
        ext_pend  <= 1'b0;
        have_prev <= 1'b0;
        triggered <= 1'b0;
      end
      if (wr_en) begin
        wr_ptr    <= wr_ptr + 1'b1;
        prev_data <= sample_data;
        have_prev <= 1'b1;
      end
      case (cur_st)
        S_FILL: if (wr_en) cnt <= cnt_inc;
        S_WAIT: begin
          if (trig_fire) begin
            trig_addr <= wr_ptr;
            triggered <= 1'b1;
            cnt       <= (SIZE+1)'(1);
          end else if (ext_trigger) begin
            ext_pend <= 1'b1;
          end
        end
        S_POST: if (wr_en) cnt <= cnt_inc;
        default: ;
      endcase
    end
  end

  // Shared-address sample RAM: all channels written as one row
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= sample_data;
  end

  // Synchronous RAM read, one row per issued word
  always_ff @(posedge clk) begin
    if (rd_issue) rd_row <= mem[rd_addr];
  end

  // Readout sequencing and valid/ready output stage
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_more    <= 1'b0;
      rd_ch      <= '0;
      rd_idx     <= '0;
      s1_v       <= 1'b0;
      s1_ch      <= '0;
      s1_last    <= 1'b0;
      data_valid <= 1'b0;
      data_out   <= '0;
      data_last  <= 1'b0;
    end else begin
      if (enter_ro) begin
        rd_more <= 1'b1;
        rd_ch   <= '0;
        rd_idx  <= '0;
      end else if (rd_issue) begin
        if (rd_is_last) begin
          rd_more <= 1'b0;
        end else if (rd_idx == rec_len - 1'b1) begin
          rd_idx <= '0;
          rd_ch  <= rd_ch + 1'b1;
        end else begin
          rd_idx <= rd_idx + 1'b1;
        end
      end
      if (rd_issue) begin
        s1_v    <= 1'b1;
        s1_ch   <= rd_ch;
        s1_last <= rd_is_last;
      end else if (out_free) begin
        s1_v <= 1'b0;
      end
      if (out_free) begin
        data_valid <= s1_v;
        data_last  <= s1_v && s1_last;
        if (s1_v) data_out <= s1_word;
      end
    end
  end

endmodule

// File: tb/tb_multi_channel_capture.sv
// tb/tb_multi_channel_capture.sv - directed self-checking bench for multi_channel_capture
module tb_multi_channel_capture;

  localparam int NCH = 4;
  localparam int W   = 12;
  localparam int SZ  = 6;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            arm = 1'b0;
  logic            sample_valid = 1'b0;
  logic [NCH*W-1:0] sample_data = '0;
  logic            ext_trigger = 1'b0;
  logic [1:0]      trig_mode = 2'b00;
  logic [NCH-1:0]  trig_chan_mask = '0;
  logic [W-1:0]    threshold = '0;
  logic [SZ-1:0]   pre_samples = '0;
  logic [SZ-1:0]   post_samples = '0;
  logic            data_ready = 1'b1;
  logic [W-1:0]    data_out;
  logic            data_valid, data_last, busy, triggered, ro_done_n;
  logic [2:0]      state;

  int checks = 0;
  int fails  = 0;
  int n = 0;
  int gen_kind = 0;
  int ext_n = -1;
  int sv_from = 0;

  multi_channel_capture #(.NCH(NCH), .WIDTH(W), .SIZE(SZ)) dut (
    .clk(clk), .reset_n(reset_n), .arm(arm), .sample_valid(sample_valid),
    .sample_data(sample_data), .ext_trigger(ext_trigger), .trig_mode(trig_mode),
    .trig_chan_mask(trig_chan_mask), .threshold(threshold), .pre_samples(pre_samples),
    .post_samples(post_samples), .data_ready(data_ready), .data_out(data_out),
    .data_valid(data_valid), .data_last(data_last), .busy(busy), .triggered(triggered),
    .ro_done_n(ro_done_n), .state(state)
  );

  always #5 clk = ~clk;

  // Channel c, sample k (k counts cycles since arm)
  function automatic logic [W-1:0] pat(input int kind, input int c, input int k);
    logic [W-1:0] v;
    v = W'(16 * c + k);
    if (kind == 1) begin
      if (c == 0) v = (k < 25) ? 12'h100 : 12'h900;
      if (c == 1) v = (k < 30) ? 12'h7FF : 12'h800;
    end else if (kind == 2) begin
      if (c == 0) v = 12'h900;
    end
    return v;
  endfunction

  task automatic drive();
    sample_valid = (n >= sv_from);
    for (int c = 0; c < NCH; c++) sample_data[c*W +: W] = pat(gen_kind, c, n);
    ext_trigger = (n == ext_n);
  endtask

  task automatic tick();
    @(negedge clk);
    n++;
    drive();
  endtask

  task automatic start_acq(input logic [1:0] mode, input logic [3:0] mask, input logic [11:0] thr,
                           input logic [5:0] pre, input logic [5:0] post, input int kind,
                           input int ext_at, input int sv_start);
    @(negedge clk);
    trig_mode = mode; trig_chan_mask = mask; threshold = thr;
    pre_samples = pre; post_samples = post;
    gen_kind = kind; ext_n = ext_at; sv_from = sv_start;
    arm = 1'b1; sample_valid = 1'b0; ext_trigger = 1'b0;
    @(negedge clk);
    arm = 1'b0;
    n = 0;
    drive();
  endtask

  task automatic wait_readout(input string tag);
    int g;
    g = 0;
    while (state !== 3'd4 && g < 300) begin tick(); g++; end
    checks++;
    if (state !== 3'd4) begin fails++; $display("FAIL %s_reach_readout: state %0d expected 4", tag, state); end
  endtask

  task automatic collect(input int total, input int len, input int nstart, input bit rnd, output int cycles);
    int k;
    bit stalled, r;
    logic [W-1:0] held, expv;
    logic held_last;
    k = 0; stalled = 0; cycles = 0; held = '0; held_last = 1'b0;
    while (k < total && cycles < 4000) begin
      if (stalled) begin
        checks++;
        if (data_valid !== 1'b1 || data_out !== held || data_last !== held_last) begin
          fails++;
          $display("FAIL stall_hold: got v=%0b d=%0h l=%0b expected v=1 d=%0h l=%0b",
                   data_valid, data_out, data_last, held, held_last);
        end
      end
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      data_ready = r;
      stalled = 0;
      if (data_valid === 1'b1) begin
        if (r) begin
          expv = pat(gen_kind, k / len, nstart + k % len);
          checks++;
          if (data_out !== expv) begin
            fails++; $display("FAIL word_%0d: got %0h expected %0h", k, data_out, expv);
          end
          checks++;
          if (data_last !== (k == total - 1)) begin
            fails++; $display("FAIL last_%0d: got %0b expected %0b", k, data_last, (k == total - 1));
          end
          k++;
        end else begin
          stalled = 1; held = data_out; held_last = data_last;
        end
      end
      tick();
      cycles++;
    end
    data_ready = 1'b1;
    checks++;
    if (k != total) begin fails++; $display("FAIL word_count: got %0d expected %0d", k, total); end
  endtask

  task automatic check_done(input string tag);
    checks++;
    if (state !== 3'd5 || ro_done_n !== 1'b0 || busy !== 1'b0 || data_valid !== 1'b0) begin
      fails++;
      $display("FAIL %s_done: state=%0d ro_done_n=%0b busy=%0b valid=%0b expected 5/0/0/0",
               tag, state, ro_done_n, busy, data_valid);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(); tick();
    checks++; if (state !== 3'd0) begin fails++; $display("FAIL rst_state: got %0d expected 0", state); end
    checks++; if (data_out !== '0) begin fails++; $display("FAIL rst_data_out: got %0h expected 0", data_out); end
    checks++; if (data_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %0b expected 0", data_valid); end
    checks++; if (data_last !== 1'b0) begin fails++; $display("FAIL rst_last: got %0b expected 0", data_last); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %0b expected 0", busy); end
    checks++; if (triggered !== 1'b0) begin fails++; $display("FAIL rst_triggered: got %0b expected 0", triggered); end
    checks++; if (ro_done_n !== 1'b1) begin fails++; $display("FAIL rst_ro_done_n: got %0b expected 1", ro_done_n); end
    reset_n = 1'b1;
  endtask

  task automatic test_ext_capture();
    int cyc;
    start_acq(2'b00, 4'hF, 12'h0, 6'd4, 6'd8, 0, 20, 0);
    while (n < 20) tick();
    checks++; if (state !== 3'd2 || triggered !== 1'b0) begin
      fails++; $display("FAIL ext_pre_trig: state=%0d trig=%0b expected 2/0", state, triggered); end
    tick();
    checks++; if (state !== 3'd3 || triggered !== 1'b1) begin
      fails++; $display("FAIL ext_post_trig: state=%0d trig=%0b expected 3/1", state, triggered); end
    wait_readout("ext");
    arm = 1'b1;
    tick();
    arm = 1'b0;
    checks++; if (state !== 3'd4 || data_valid !== 1'b0) begin
      fails++; $display("FAIL ext_latency1: state=%0d valid=%0b expected 4/0", state, data_valid); end
    tick();
    checks++; if (data_valid !== 1'b1) begin
      fails++; $display("FAIL ext_latency2: valid=%0b expected 1", data_valid); end
    collect(48, 12, 16, 1'b0, cyc);
    checks++; if (cyc != 48) begin fails++; $display("FAIL ext_throughput: got %0d cycles expected 48", cyc); end
    check_done("ext");
  endtask

  task automatic test_self_trigger();
    int cyc;
    start_acq(2'b01, 4'b0010, 12'h800, 6'd4, 6'd4, 1, -1, 0);
    while (n < 30) tick();
    checks++; if (state !== 3'd2 || triggered !== 1'b0) begin
      fails++; $display("FAIL self_pre_trig: state=%0d trig=%0b expected 2/0", state, triggered); end
    tick();
    checks++; if (state !== 3'd3 || triggered !== 1'b1) begin
      fails++; $display("FAIL self_post_trig: state=%0d trig=%0b expected 3/1", state, triggered); end
    wait_readout("self");
    collect(32, 8, 26, 1'b0, cyc);
    check_done("self");
  endtask

  task automatic test_self_no_trigger();
    start_acq(2'b01, 4'b0001, 12'h800, 6'd2, 6'd2, 2, -1, 0);
    repeat (40) tick();
    checks++; if (state !== 3'd2 || triggered !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL self_none: state=%0d trig=%0b busy=%0b expected 2/0/1", state, triggered, busy); end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    checks++; if (state !== 3'd0) begin fails++; $display("FAIL self_none_reset: state %0d expected 0", state); end
  endtask

  task automatic test_clamp_wrap();
    int cyc;
    start_acq(2'b00, 4'hF, 12'h0, 6'd40, 6'd40, 0, 50, 0);
    wait_readout("clamp");
    collect(4 * 63, 63, 10, 1'b0, cyc);
    check_done("clamp");
  endtask

  task automatic test_backpressure();
    int cyc;
    start_acq(2'b10, 4'h0, 12'h0, 6'd4, 6'd8, 0, 20, 0);
    wait_readout("bp");
    collect(48, 12, 16, 1'b1, cyc);
    check_done("bp");
  endtask

  task automatic test_fill_trigger_and_reset();
    start_acq(2'b00, 4'h0, 12'h0, 6'd10, 6'd30, 0, 3, 0);
    repeat (30) tick();
    checks++; if (state !== 3'd2 || triggered !== 1'b0) begin
      fails++; $display("FAIL fill_trig_ignored: state=%0d trig=%0b expected 2/0", state, triggered); end
    ext_n = n + 2;
    tick(); tick(); tick();
    checks++; if (state !== 3'd3 || triggered !== 1'b1) begin
      fails++; $display("FAIL late_trig: state=%0d trig=%0b expected 3/1", state, triggered); end
    repeat (3) tick();
    reset_n = 1'b0;
    tick();
    checks++; if (state !== 3'd0 || busy !== 1'b0 || triggered !== 1'b0 || ro_done_n !== 1'b1) begin
      fails++; $display("FAIL post_reset_ctl: state=%0d busy=%0b trig=%0b ro_done_n=%0b expected 0/0/0/1",
                        state, busy, triggered, ro_done_n); end
    checks++; if (data_out !== '0 || data_valid !== 1'b0 || data_last !== 1'b0) begin
      fails++; $display("FAIL post_reset_data: d=%0h v=%0b l=%0b expected 0/0/0", data_out, data_valid, data_last); end
    reset_n = 1'b1;
    ext_n = -1;
  endtask

  task automatic test_min_record();
    int cyc;
    start_acq(2'b00, 4'h0, 12'h0, 6'd0, 6'd0, 0, 1, 1);
    wait_readout("min");
    collect(NCH, 1, 1, 1'b0, cyc);
    check_done("min");
  endtask

  initial begin
    test_reset();
    test_ext_capture();
    test_self_trigger();
    test_self_no_trigger();
    test_clamp_wrap();
    test_backpressure();
    test_fill_trigger_and_reset();
    test_min_record();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
